bcd_count_sequencer: RTL and testbench
======================================

// Module: bcd_count_sequencer
// PURPOSE
//  Run controller for the 3-digit multi-decade BCD counter. Owns the counter's enable and clear.
//  Generates count ticks from a prescaler and executes start/stop/clear commands.
//  Stops on a programmable BCD target or on 999->000 rollover, and raises a one-cycle irq.
//  Sits between the control/register interface and the counter instance.
// PARAMETERS
//  PRESCALE  50000  clk cycles per count tick, >=2
//  WRAP      0      0: rollover ends the run (DONE); 1: rollover flags overflow and keeps running
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   pulse: IDLE -> clear+run; PAUSE -> resume
//  stop         in   1   pulse: RUN -> PAUSE
//  clear        in   1   pulse: any state -> clear counter, return to IDLE
//  target_en    in   1   1: stop on target match; 0: free count
//  target_bcd   in   12  {hundreds,tens,ones}; latched on start from IDLE
//  cnt_ones     in   4   counter ones digit
//  cnt_tens     in   4   counter tens digit
//  cnt_hundreds in   4   counter hundreds digit
//  cnt_done     in   1   counter terminal carry (high when enable & value==999)
//  cnt_enable   out  1   registered one-cycle count pulse to counter
//  cnt_clear_n  out  1   registered active-low clear to counter, one cycle
//  state        out  3   current FSM state encoding
//  busy         out  1   state is CLEAR, RUN or PAUSE
//  match        out  1   sticky: run ended on target
//  overflow     out  1   sticky: 999->000 rollover occurred this run
//  irq          out  1   one-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset values: state=IDLE, cnt_enable=0, cnt_clear_n=1, match=0, overflow=0, irq=0,
//    prescaler=0, target_q=0.
//  States: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4. Other codes decode to IDLE next cycle.
//  Command priority within a cycle: clear > stop > start. Unlisted command/state pairs are ignored.
//    - clear: any state -> CLEAR. Sets the return-to-IDLE flag and zeroes match, overflow and prescaler.
//    - start in IDLE: latch target_q=target_bcd -> CLEAR (run flag set).
//    - CLEAR: cnt_clear_n=0 for exactly this cycle. Next state is RUN if run flag set, else IDLE.
//    - start in PAUSE: -> RUN. Prescaler value is retained, so no partial tick is lost.
//    - stop in RUN: -> PAUSE. A cnt_enable already registered this cycle still occurs.
//    - start in RUN/DONE, stop outside RUN: ignored. DONE exits only via clear.
//  Prescaler advances only in RUN and wraps at PRESCALE-1. The wrap cycle registers cnt_enable=1
//    for the next cycle, so ticks are exactly PRESCALE clks apart. First tick comes PRESCALE+1
//    cycles after entering RUN.
//  Rollover: cnt_done is sampled while cnt_enable=1.
//    - If high, overflow<=1 next cycle.
//    - WRAP=0: -> DONE, match unchanged.
//    - WRAP=1: stay in RUN.
//  Target: evaluated only in the cycle after a cnt_enable pulse, when the digits are settled.
//    - If target_en & {cnt_hundreds,cnt_tens,cnt_ones}==target_q: match<=1, -> DONE.
//    - target_q with any digit >9 never matches. target_q==000 matches only after a rollover
//      (WRAP=1); with WRAP=0 the overflow exit wins.
//    - target_bcd changes mid-run have no effect.
//  irq: asserted the first cycle state==DONE, exactly one cycle per entry.
//  cnt_enable is never high in IDLE, CLEAR, PAUSE or DONE (except the single in-flight pulse on stop).
//    It is never high in the same cycle as cnt_clear_n=0.
//  Async reset mid-run: all outputs return to reset values immediately. The counter's own reset
//    is driven separately.
// STRUCTURE
//  Shared package bcd_ctrl_pkg: state encodings (ST_IDLE..ST_DONE, 3 bits), BCD digit width = 4,
//    digit count = 3, BCD_MAX = 12'h999.
//  Sub-module tick_prescaler (PRESCALE): inputs run and zero, output tick. Counter width is
//    $clog2(PRESCALE).
//  FSM, target compare and sticky flags live in this module.
// TESTING  (PRESCALE=4, counter instance attached)
//  - Reset, start, target_en=1, target=12'h005 -> clear_n low 1 cycle; 5 cnt_enable pulses 4 clks
//    apart; match=1, irq once, state=DONE at count 005.
//  - start, stop after 2 ticks, wait 20 clks, start -> no ticks while PAUSE; count resumes at 002;
//    next tick spacing is unchanged.
//  - target_en=0, WRAP=0, run 1000 ticks -> overflow=1, match=0, state=DONE, count=000.
//  - WRAP=1, target=000, run 1000 ticks -> overflow=1 and match=1 the same run, state=DONE.
//  - clear, stop and start all asserted together in RUN -> CLEAR then IDLE; flags zero; count 000.
//  - Reset asserted mid-RUN between ticks -> outputs at reset values asynchronously;
//    target=12'h00A never matches.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD counter run controller: state encodings,
// digit geometry and a BCD validity helper.
package bcd_ctrl_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 3;
  localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

  localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // A value with any digit above 9 can never be shown by the counter.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider for count ticks: advances only while run is high and
// reports the wrap cycle on tick. zero forces the count back to 0.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (zero) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_count_sequencer.sv
// Run controller for the 3-digit BCD counter: owns its enable and clear,
// paces count ticks, and ends a run on target match or rollover.
module bcd_count_sequencer
  import bcd_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter bit WRAP     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             target_en,
  input  logic [BCD_W-1:0] target_bcd,
  input  logic [3:0]       cnt_ones,
  input  logic [3:0]       cnt_tens,
  input  logic [3:0]       cnt_hundreds,
  input  logic             cnt_done,
  output logic             cnt_enable,
  output logic             cnt_clear_n,
  output logic [2:0]       state,
  output logic             busy,
  output logic             match,
  output logic             overflow,
  output logic             irq
);

  // start/stop/clear are single-cycle command pulses sampled on posedge clk;
  // within one cycle clear beats stop, and stop beats start.

  seq_state_e       state_q, state_d;
  logic             run_q, run_d;
  logic [BCD_W-1:0] target_q, target_d;
  logic             match_q, match_d;
  logic             overflow_q, overflow_d;
  logic             cnt_enable_q, cnt_enable_d;
  logic             cnt_clear_n_q, cnt_clear_n_d;
  logic             irq_q, irq_d;
  logic             settle_q;

  logic             presc_run, presc_zero, tick;
  logic [BCD_W-1:0] cnt_bcd;
  logic             rollover, target_hit;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .reset (reset),
    .run   (presc_run),
    .zero  (presc_zero),
    .tick  (tick)
  );

  assign cnt_bcd    = {cnt_hundreds, cnt_tens, cnt_ones};
  assign rollover   = cnt_enable_q && cnt_done;
  // settle_q marks the cycle after a pulse, when the counter digits are stable.
  assign target_hit = target_en && settle_q && bcd_valid(target_q) && (cnt_bcd == target_q);
  assign presc_run  = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    target_d   = target_q;
    match_d    = match_q;
    overflow_d = overflow_q;
    presc_zero = (state_q == ST_CLEAR);

    if (rollover) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = target_bcd;
          run_d    = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = run_q ? ST_RUN : ST_IDLE;
      ST_RUN, ST_PAUSE: begin
        // A run-ending event outranks stop/start so an in-flight last tick still ends the run.
        if (rollover && !WRAP) begin
          state_d = ST_DONE;
        end else if (target_hit) begin
          match_d = 1'b1;
          state_d = ST_DONE;
        end else if (state_q == ST_RUN && stop) begin
          state_d = ST_PAUSE;
        end else if (state_q == ST_PAUSE && start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d    = ST_CLEAR;
      run_d      = 1'b0;
      match_d    = 1'b0;
      overflow_d = 1'b0;
      presc_zero = 1'b1;
    end

    // A tick on the stop cycle is kept; one on a clear or run-ending cycle is dropped.
    cnt_enable_d  = tick && ((state_d == ST_RUN) || (state_d == ST_PAUSE));
    cnt_clear_n_d = (state_d != ST_CLEAR);
    irq_d         = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      run_q         <= 1'b0;
      target_q      <= '0;
      match_q       <= 1'b0;
      overflow_q    <= 1'b0;
      cnt_enable_q  <= 1'b0;
      cnt_clear_n_q <= 1'b1;
      irq_q         <= 1'b0;
      settle_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      target_q      <= target_d;
      match_q       <= match_d;
      overflow_q    <= overflow_d;
      cnt_enable_q  <= cnt_enable_d;
      cnt_clear_n_q <= cnt_clear_n_d;
      irq_q         <= irq_d;
      settle_q      <= cnt_enable_q;
    end
  end

  assign cnt_enable  = cnt_enable_q;
  assign cnt_clear_n = cnt_clear_n_q;
  assign state       = state_q;
  assign busy        = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign match       = match_q;
  assign overflow    = overflow_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Bench for bcd_count_sequencer: two instances (WRAP=0 and WRAP=1) share the
// command inputs, each driving its own behavioural 3-digit BCD counter.
module tb_bcd_count_sequencer;
  import bcd_ctrl_pkg::*;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, target_en = 1'b0;
  logic [11:0] target_bcd = 12'h000;

  logic [11:0] cnt0, cnt1;
  logic        done0, done1, en0, en1, clrn0, clrn1;
  logic        busy0, busy1, match0, match1, ovf0, ovf1, irq0, irq1;
  logic [2:0]  st0, st1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_q[$];

  int   n_ticks = 0, irq_cnt0 = 0, irq_cnt1 = 0;
  int   active = 0, last_active = 0;
  logic have_last = 1'b0, pend = 1'b0, mon_en = 1'b0;
  int   tick_base, irq_base0, irq_base1;

  always #5 clk = ~clk;

  bcd_count_sequencer #(.PRESCALE(P), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .target_en(target_en), .target_bcd(target_bcd),
    .cnt_ones(cnt0[3:0]), .cnt_tens(cnt0[7:4]), .cnt_hundreds(cnt0[11:8]), .cnt_done(done0),
    .cnt_enable(en0), .cnt_clear_n(clrn0), .state(st0), .busy(busy0),
    .match(match0), .overflow(ovf0), .irq(irq0)
  );

  bcd_count_sequencer #(.PRESCALE(P), .WRAP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .target_en(target_en), .target_bcd(target_bcd),
    .cnt_ones(cnt1[3:0]), .cnt_tens(cnt1[7:4]), .cnt_hundreds(cnt1[11:8]), .cnt_done(done1),
    .cnt_enable(en1), .cnt_clear_n(clrn1), .state(st1), .busy(busy1),
    .match(match1), .overflow(ovf1), .irq(irq1)
  );

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Counter instances: synchronous clear, enable-driven increment, carry at 999.
  always @(posedge clk or posedge reset) begin
    if (reset)       cnt0 <= 12'h000;
    else if (!clrn0) cnt0 <= 12'h000;
    else if (en0)    cnt0 <= bcd_inc(cnt0);
  end
  always @(posedge clk or posedge reset) begin
    if (reset)       cnt1 <= 12'h000;
    else if (!clrn1) cnt1 <= 12'h000;
    else if (en1)    cnt1 <= bcd_inc(cnt1);
  end
  assign done0 = en0 && (cnt0 == BCD_MAX);
  assign done1 = en1 && (cnt1 == BCD_MAX);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor on instance 0: each tick pops the expected count.
  always @(negedge clk) begin
    if (!reset) begin
      irq_cnt0 += int'(irq0);
      irq_cnt1 += int'(irq1);
      if (st0 != ST_PAUSE) active++;
      if (st0 == ST_IDLE || st0 == ST_CLEAR) have_last = 1'b0;
      if (st0 == ST_PAUSE) check_eq("pause_no_tick", en0, 0);
      if (!clrn0) check_eq("clr_no_tick", en0, 0);
      if (mon_en) begin
        if (pend) begin
          check_eq("tick_has_exp", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check_eq("tick_value", cnt0, exp_q.pop_front());
        end
        pend = en0;
        if (en0) begin
          n_ticks++;
          if (have_last) check_eq("tick_gap", active - last_active, P);
          have_last   = 1'b1;
          last_active = active;
        end
      end
    end
  end

  task automatic cmd(input logic c, input logic s, input logic g);
    @(negedge clk);
    clear = c; stop = s; start = g;
    @(negedge clk);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic push_counts(input logic [11:0] from, input int n);
    logic [11:0] v;
    v = from;
    for (int i = 0; i < n; i++) begin
      v = bcd_inc(v);
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_st0(input logic [2:0] want, input int budget, input string tag);
    int n;
    n = 0;
    while (st0 != want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, st0, want);
  endtask

  task automatic wait_ticks(input int want, input int budget, input string tag);
    int n;
    n = 0;
    while ((n_ticks - tick_base) < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, n_ticks - tick_base, want);
  endtask

  task automatic check_reset(input string t);
    check_eq({t, "_st0"}, st0, ST_IDLE);
    check_eq({t, "_en0"}, en0, 0);
    check_eq({t, "_clrn0"}, clrn0, 1);
    check_eq({t, "_match0"}, match0, 0);
    check_eq({t, "_ovf0"}, ovf0, 0);
    check_eq({t, "_irq0"}, irq0, 0);
    check_eq({t, "_busy0"}, busy0, 0);
    check_eq({t, "_st1"}, st1, ST_IDLE);
    check_eq({t, "_en1"}, en1, 0);
    check_eq({t, "_clrn1"}, clrn1, 1);
    check_eq({t, "_match1"}, match1, 0);
    check_eq({t, "_ovf1"}, ovf1, 0);
  endtask

  task automatic arm_run();
    tick_base = n_ticks;
    irq_base0 = irq_cnt0;
    irq_base1 = irq_cnt1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Target 005: five ticks then DONE with match and a single irq.
    target_en = 1'b1; target_bcd = 12'h005;
    push_counts(12'h000, 5);
    arm_run();
    cmd(1'b0, 1'b0, 1'b1);
    check_eq("t1_clear_state", st0, ST_CLEAR);
    check_eq("t1_clear_n_low", clrn0, 0);
    check_eq("t1_busy", busy0, 1);
    @(negedge clk);
    check_eq("t1_run_state", st0, ST_RUN);
    check_eq("t1_clear_n_high", clrn0, 1);
    wait_st0(ST_DONE, 80, "t1_done");
    repeat (4) @(negedge clk);
    check_eq("t1_count", cnt0, 12'h005);
    check_eq("t1_match0", match0, 1);
    check_eq("t1_match1", match1, 1);
    check_eq("t1_ovf0", ovf0, 0);
    check_eq("t1_irq0", irq_cnt0 - irq_base0, 1);
    check_eq("t1_irq1", irq_cnt1 - irq_base1, 1);
    check_eq("t1_ticks", n_ticks - tick_base, 5);
    check_eq("t1_busy_done", busy0, 0);
    cmd(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t1_idle", st0, ST_IDLE);
    check_eq("t1_match_cleared", match0, 0);

    // Pause after two ticks, resume, then clear+stop+start together.
    target_en = 1'b0;
    push_counts(12'h000, 5);
    arm_run();
    cmd(1'b0, 1'b0, 1'b1);
    wait_ticks(2, 40, "t2_two_ticks");
    cmd(1'b0, 1'b1, 1'b0);
    check_eq("t2_pause", st0, ST_PAUSE);
    repeat (20) @(negedge clk);
    check_eq("t2_pause_ticks", n_ticks - tick_base, 2);
    check_eq("t2_pause_count", cnt0, 12'h002);
    check_eq("t2_pause_busy", busy0, 1);
    cmd(1'b0, 1'b0, 1'b1);
    check_eq("t2_resume", st0, ST_RUN);
    wait_ticks(5, 60, "t2_five_ticks");
    cmd(1'b1, 1'b1, 1'b1);
    check_eq("t5_clear_state", st0, ST_CLEAR);
    check_eq("t5_clear_n", clrn0, 0);
    @(negedge clk);
    check_eq("t5_idle", st0, ST_IDLE);
    check_eq("t5_idle1", st1, ST_IDLE);
    check_eq("t5_match", match0, 0);
    check_eq("t5_ovf", ovf0, 0);
    check_eq("t5_count0", cnt0, 12'h000);
    check_eq("t5_count1", cnt1, 12'h000);
    check_eq("t5_queue", exp_q.size(), 0);

    // Free count through 999->000.
    push_counts(12'h000, 1000);
    arm_run();
    cmd(1'b0, 1'b0, 1'b1);
    wait_st0(ST_DONE, 4300, "t3_done");
    repeat (3) @(negedge clk);
    check_eq("t3_ovf0", ovf0, 1);
    check_eq("t3_match0", match0, 0);
    check_eq("t3_count0", cnt0, 12'h000);
    check_eq("t3_irq0", irq_cnt0 - irq_base0, 1);
    check_eq("t3_ticks", n_ticks - tick_base, 1000);
    check_eq("t3_st1_running", st1, ST_RUN);
    check_eq("t3_ovf1", ovf1, 1);
    check_eq("t3_match1", match1, 0);
    cmd(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t3_ovf_cleared", ovf1, 0);

    // Target 000: only the wrapping instance can match it, after rollover.
    target_en = 1'b1; target_bcd = 12'h000;
    push_counts(12'h000, 1000);
    arm_run();
    cmd(1'b0, 1'b0, 1'b1);
    wait_st0(ST_DONE, 4300, "t4_done");
    repeat (3) @(negedge clk);
    check_eq("t4_ovf0", ovf0, 1);
    check_eq("t4_match0", match0, 0);
    check_eq("t4_st1", st1, ST_DONE);
    check_eq("t4_ovf1", ovf1, 1);
    check_eq("t4_match1", match1, 1);
    check_eq("t4_count1", cnt1, 12'h000);
    check_eq("t4_irq1", irq_cnt1 - irq_base1, 1);
    cmd(1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Invalid target 00A, then asynchronous reset between ticks.
    target_bcd = 12'h00A;
    push_counts(12'h000, 12);
    arm_run();
    cmd(1'b0, 1'b0, 1'b1);
    wait_ticks(12, 80, "t6_ticks");
    repeat (2) @(negedge clk);
    check_eq("t6_still_run", st0, ST_RUN);
    check_eq("t6_no_match", match0, 0);
    check_eq("t6_count", cnt0, 12'h012);
    check_eq("t6_queue", exp_q.size(), 0);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset("async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
